alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 189 ++++++++++++++++++
 tb/tb_alu_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked EX-stage ALU. Single-cycle ops and iterative MULU/DIVU
// share one output register stage written on the first cycle of DONE.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready request handshake; in_ready is high only in IDLE
//   oprd1, oprd2        operands a, b (captured on accept)
//   option              4-bit operation code
//   out_valid/out_ready result handshake; outputs held until out_ready
//   result, hi          primary result; HI / remainder for MULU / DIVU
//   zero, div0, illegal status flags registered with result
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] oprd1,
  input  logic [WIDTH-1:0] oprd2,
  input  logic [3:0]       option,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             div0,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_MULU = 4'b1000,
    OP_DIVU = 4'b1001,
    OP_SRA  = 4'b1010,
    OP_NOR  = 4'b1100,
    OP_LUI  = 4'b1101,
    OP_MOVE = 4'b1111
  } op_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r, b_r;
  op_t              op_r;

  // MUL: {hi-accumulator, multiplier a shifting out at the bottom}
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     mul_sum;

  // DIV: quotient register initially holds the dividend, shifting left
  logic [WIDTH-1:0] quo, rem;
  logic [WIDTH:0]   div_shift;
  logic             div_neg;
  logic [WIDTH-1:0] div_diff;

  logic             start_eng;
  logic [WIDTH-1:0] fin_res, fin_hi;
  logic             fin_div0, fin_ill;

  assign in_ready  = (state == IDLE);
  assign start_eng = (option == OP_MULU) || ((option == OP_DIVU) && (oprd2 != '0));

  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_r} : '0);

  // Guard bit lives in div_shift[WIDTH]; when no borrow the difference fits WIDTH bits.
  assign div_shift = {rem, quo[WIDTH-1]};
  assign div_neg   = (div_shift < {1'b0, b_r});
  assign div_diff  = div_shift[WIDTH-1:0] - b_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = start_eng ? BUSY : DONE;
      BUSY:    if (cnt == CW'(1)) state_nx = DONE;
      DONE:    if (out_valid && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    fin_res  = '0;
    fin_hi   = '0;
    fin_div0 = 1'b0;
    fin_ill  = 1'b0;
    case (op_r)
      OP_AND:  fin_res = a_r & b_r;
      OP_OR:   fin_res = a_r | b_r;
      OP_ADD:  fin_res = a_r + b_r;
      OP_XOR:  fin_res = a_r ^ b_r;
      OP_SLL:  fin_res = b_r << a_r[SHW-1:0];
      OP_SRL:  fin_res = b_r >> a_r[SHW-1:0];
      OP_SUB:  fin_res = a_r - b_r;
      OP_SLT:  fin_res = {{(WIDTH-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
      OP_SRA:  fin_res = $signed(b_r) >>> a_r[SHW-1:0];
      OP_NOR:  fin_res = ~(a_r | b_r);
      OP_LUI:  fin_res = b_r << (WIDTH / 2);
      OP_MOVE: fin_res = a_r;
      OP_MULU: begin
        fin_res = acc[WIDTH-1:0];
        fin_hi  = acc[2*WIDTH-1:WIDTH];
      end
      OP_DIVU: begin
        if (b_r == '0) begin
          fin_res  = '1;
          fin_hi   = a_r;
          fin_div0 = 1'b1;
        end else begin
          fin_res = quo;
          fin_hi  = rem;
        end
      end
      default: fin_ill = 1'b1;
    endcase
  end

  // Both paths enter DONE with out_valid low; the first DONE cycle loads the
  // output registers, giving the extra registered cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= OP_AND;
      acc       <= '0;
      quo       <= '0;
      rem       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      hi        <= '0;
      zero      <= 1'b0;
      div0      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r  <= oprd1;
            b_r  <= oprd2;
            op_r <= op_t'(option);
            cnt  <= start_eng ? CW'(WIDTH) : '0;
            acc  <= {{WIDTH{1'b0}}, oprd1};
            quo  <= oprd1;
            rem  <= '0;
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          if (op_r == OP_MULU) begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end else begin
            rem <= div_neg ? div_shift[WIDTH-1:0] : div_diff;
            quo <= {quo[WIDTH-2:0], ~div_neg};
          end
        end
        DONE: begin
          if (!out_valid) begin
            result    <= fin_res;
            hi        <= fin_hi;
            zero      <= (fin_res == '0);
            div0      <= fin_div0;
            illegal   <= fin_ill;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized self-checking bench for alu_seq at WIDTH=32 and
// WIDTH=16, compared against an arithmetic reference model.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // index 0: WIDTH=32 instance, index 1: WIDTH=16 instance
  logic        iv   [2];
  logic [31:0] ia   [2];
  logic [31:0] ib   [2];
  logic [3:0]  iop  [2];
  logic        ordy [2];

  logic        rdy32, ov32, z32, d032, il32;
  logic [31:0] res32, hi32;
  logic        rdy16, ov16, z16, d016, il16;
  logic [15:0] res16, hi16;

  logic        vrdy [2];
  logic        vov  [2];
  logic        vz   [2];
  logic        vd0  [2];
  logic        vill [2];
  logic [31:0] vres [2];
  logic [31:0] vhi  [2];

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy32),
    .oprd1(ia[0]), .oprd2(ib[0]), .option(iop[0]),
    .out_valid(ov32), .out_ready(ordy[0]), .result(res32), .hi(hi32),
    .zero(z32), .div0(d032), .illegal(il32)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy16),
    .oprd1(ia[1][15:0]), .oprd2(ib[1][15:0]), .option(iop[1]),
    .out_valid(ov16), .out_ready(ordy[1]), .result(res16), .hi(hi16),
    .zero(z16), .div0(d016), .illegal(il16)
  );

  always_comb begin
    vrdy[0] = rdy32; vov[0] = ov32; vz[0] = z32; vd0[0] = d032; vill[0] = il32;
    vres[0] = res32; vhi[0] = hi32;
    vrdy[1] = rdy16; vov[1] = ov16; vz[1] = z16; vd0[1] = d016; vill[1] = il16;
    vres[1] = {16'd0, res16}; vhi[1] = {16'd0, hi16};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: direct arithmetic on 64-bit values, masked to w bits.
  function automatic void model(input int unsigned w, input logic [63:0] a, input logic [63:0] b,
                                input logic [3:0] op,
                                output logic [63:0] res, output logic [63:0] hv,
                                output logic z, output logic d0, output logic ill,
                                output int unsigned lat);
    logic [63:0] m, p;
    logic signed [63:0] sa, sb;
    int unsigned sh;
    m   = (64'd1 << w) - 64'd1;
    sa  = $signed(a[w-1] ? (a | ~m) : a);
    sb  = $signed(b[w-1] ? (b | ~m) : b);
    sh  = 32'(a % 64'(w));
    res = '0; hv = '0; d0 = 1'b0; ill = 1'b0; lat = 1;
    case (op)
      4'h0: res = a & b;
      4'h1: res = a | b;
      4'h2: res = (a + b) & m;
      4'h3: res = a ^ b;
      4'h4: res = (b << sh) & m;
      4'h5: res = b >> sh;
      4'h6: res = (a - b) & m;
      4'h7: res = (sa < sb) ? 64'd1 : 64'd0;
      4'h8: begin
        p = a * b;
        res = p & m;
        hv  = p >> w;
        lat = w + 1;
      end
      4'h9: begin
        if (b == 0) begin
          res = m; hv = a; d0 = 1'b1;
        end else begin
          res = a / b; hv = a % b; lat = w + 1;
        end
      end
      4'hA: res = 64'(sb >>> sh) & m;
      4'hC: res = ~(a | b) & m;
      4'hD: res = (b << (w / 2)) & m;
      4'hF: res = a;
      default: ill = 1'b1;
    endcase
    z = (res == 0);
  endfunction

  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input int hold);
    logic [63:0] er, eh, m;
    logic ez, ed, ei;
    int unsigned lat, w, cnt;
    w = (sel == 1) ? 16 : 32;
    m = (64'd1 << w) - 64'd1;
    model(w, {32'd0, a} & m, {32'd0, b} & m, op, er, eh, ez, ed, ei, lat);

    check("in_ready_idle", 64'(vrdy[sel]), 64'd1);
    iv[sel] = 1'b1; ia[sel] = a; ib[sel] = b; iop[sel] = op;
    @(posedge clk); #1;
    iv[sel] = 1'b0; ia[sel] = $urandom; ib[sel] = $urandom; iop[sel] = 4'($urandom);

    cnt = 0;
    while (!vov[sel] && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("latency", 64'(cnt), 64'(lat));
    check("result", 64'(vres[sel]), er);
    check("hi", 64'(vhi[sel]), eh);
    check("flags", {61'd0, vz[sel], vd0[sel], vill[sel]}, {61'd0, ez, ed, ei});

    // Backpressure with a competing request that must be ignored
    for (int i = 0; i < hold; i++) begin
      iv[sel] = 1'b1; iop[sel] = 4'($urandom);
      @(posedge clk); #1;
      check("hold_result", 64'(vres[sel]), er);
      check("hold_hi", 64'(vhi[sel]), eh);
      check("hold_ctrl", {59'd0, vov[sel], vrdy[sel], vz[sel], vd0[sel], vill[sel]},
            {59'd0, 1'b1, 1'b0, ez, ed, ei});
    end
    iv[sel] = 1'b0;
    ordy[sel] = 1'b1;
    @(posedge clk); #1;
    ordy[sel] = 1'b0;
    check("release", {62'd0, vov[sel], vrdy[sel]}, {62'd0, 1'b0, 1'b1});
  endtask

  initial begin
    logic seen;
    logic [3:0] op;
    logic [31:0] a, b;
    for (int s = 0; s < 2; s++) begin
      iv[s] = 1'b0; ia[s] = '0; ib[s] = '0; iop[s] = '0; ordy[s] = 1'b0;
    end

    #1;
    check("reset_outs", {res32, hi32}, 64'd0);
    check("reset_ctrl", {58'd0, ov32, rdy32, z32, d032, il32, ov16}, {58'd0, 6'b010000});
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed WIDTH=32 cases
    run_op(0, 32'd5, 32'd5, 4'b0110, 0);
    run_op(0, 32'hFFFF_FFFF, 32'd1, 4'b0111, 0);
    run_op(0, 32'd4, 32'h8000_0000, 4'b1010, 0);
    run_op(0, 32'h0, 32'h1234, 4'b1101, 0);
    run_op(0, 32'h55, 32'hAA, 4'b1011, 0);
    run_op(0, 32'h55, 32'hAA, 4'b1110, 0);
    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1000, 0);
    run_op(0, 32'd9, 32'd0, 4'b1001, 0);
    run_op(0, 32'd100, 32'd7, 4'b1001, 20);

    // Reset in the middle of a MULU: outputs clear, in-flight op discarded
    iv[0] = 1'b1; ia[0] = 32'hFFFF_FFFF; ib[0] = 32'h1234_5678; iop[0] = 4'b1000;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_outs", {res32, hi32}, 64'd0);
    check("midreset_ctrl", {59'd0, ov32, rdy32, z32, d032, il32}, {59'd0, 5'b01000});
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ov32 || !rdy32) seen = 1'b1;
    end
    check("no_ghost_result", 64'(seen), 64'd0);
    run_op(0, 32'd3, 32'd4, 4'b0010, 0);

    // Directed WIDTH=16 cases
    run_op(1, 32'hFFFF, 32'h0002, 4'b1000, 0);
    run_op(1, 32'h13, 32'h0101, 4'b0100, 0);
    run_op(1, 32'd50000, 32'd0, 4'b1001, 3);

    // Randomized traffic on both instances
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if (op == 4'b1001 && $urandom_range(0, 3) == 0) b = '0;
      else if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 255));
      run_op(0, a, b, op, $urandom_range(0, 3));
    end
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if (op == 4'b1001 && $urandom_range(0, 3) == 0) b = '0;
      run_op(1, a, b, op, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
